// File: rtl/if_fetch_stage.sv
// if_fetch_stage: owns the fetch PC, keeps one instruction-memory request in flight
// and presents the buffered word to IF/ID, or NOP when nothing valid is held.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic        inst_valid
);
   typedef enum logic [1:0] {IDLE, WAIT, FULL} state_e;
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, req_pc_q, req_pc_d, inst_buf_q, inst_buf_d, buf_pc_q, buf_pc_d;
   logic        kill_q, kill_d, full, rsp;
   assign full       = state_q == FULL;
   assign rsp        = state_q == WAIT && imem_rvalid;
   assign imem_req   = rst && !redirect && (state_q == IDLE || (full && !stall));
   assign imem_addr  = pc_q;
   assign inst       = full ? inst_buf_q : NOP_INST;
   assign pc         = full ? buf_pc_q : '0;
   assign inst_valid = full;
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      req_pc_d   = req_pc_q;
      inst_buf_d = inst_buf_q;
      buf_pc_d   = buf_pc_q;
      kill_d     = rsp ? 1'b0 : kill_q;
      // a redirect with a request still in flight keeps waiting but poisons that response
      if (redirect) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         kill_d  = state_q == WAIT && !imem_rvalid;
         state_d = (state_q == WAIT && !imem_rvalid) ? WAIT : IDLE;
      end else if (imem_req && imem_gnt) begin
         req_pc_d = pc_q;
         pc_d     = pc_q + 32'd4;
         state_d  = WAIT;
      end else if (full && !stall) begin
         state_d = IDLE;
      end else if (rsp) begin
         state_d    = kill_q ? IDLE : FULL;
         inst_buf_d = imem_rdata;
         buf_pc_d   = req_pc_q;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         pc_q       <= RESET_PC;
         req_pc_q   <= '0;
         inst_buf_q <= '0;
         buf_pc_q   <= '0;
         kill_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         req_pc_q   <= req_pc_d;
         inst_buf_q <= inst_buf_d;
         buf_pc_q   <= buf_pc_d;
         kill_q     <= kill_d;
      end
   end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: memory model plus fetch-order scoreboard around if_fetch_stage.
module tb_if_fetch_stage;
   localparam logic [31:0] RPC = 32'h0000_0000;
   localparam logic [31:0] NOP = 32'h0000_0013;
   localparam logic [31:0] KEY = 32'hA5A5_0000;
   logic        clk, rst, stall, redirect, imem_req, imem_gnt, imem_rvalid, inst_valid;
   logic [31:0] redirect_pc, imem_addr, imem_rdata, inst, pc;
   int          n_tests = 0, n_fail = 0, mem_lat = 1, cnt = 0;
   bit          pend = 0, pv = 0;
   logic [31:0] paddr = '0, mpc = RPC;
   logic [63:0] q[$];
   logic [63:0] e;
   logic [5:0]  vbits;
   if_fetch_stage #(.RESET_PC(RPC), .NOP_INST(NOP)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .inst(inst), .pc(pc), .inst_valid(inst_valid)
   );
   initial clk = 0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_valid(input string tag, input logic [31:0] exp_pc);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (inst_valid) break;
      end
      check({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
      check({tag, "_pc"}, pc, exp_pc);
   endtask
   // memory: response mem_lat cycles after the grant cycle, no knowledge of DUT resets
   always @(posedge clk) begin
      imem_rvalid <= 1'b0;
      if (pend && cnt == 1) begin
         imem_rvalid <= 1'b1;
         imem_rdata  <= paddr ^ KEY;
         pend        <= 1'b0;
      end else if (pend) cnt <= cnt - 1;
      if (imem_req && imem_gnt) begin
         if (mem_lat <= 1) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= imem_addr ^ KEY;
         end else begin
            pend  <= 1'b1;
            cnt   <= mem_lat - 1;
            paddr <= imem_addr;
         end
      end
   end
   // scoreboard: expected {pc,inst} pushed at grant, dropped on redirect, popped on delivery
   always @(negedge clk) begin
      if (!rst) begin
         q.delete();
         mpc = RPC;
         pv  = 0;
      end else begin
         if (inst_valid && !pv) begin
            if (q.size() == 0) check("unexpected_valid", {31'b0, inst_valid}, 32'd0);
            else begin
               e = q.pop_front();
               check("sb_pc", pc, e[63:32]);
               check("sb_inst", inst, e[31:0]);
            end
         end
         if (!inst_valid) begin
            check("nop_inst", inst, NOP);
            check("nop_pc", pc, 32'd0);
         end
         if (redirect) begin
            check("req_on_redirect", {31'b0, imem_req}, 32'd0);
            if (q.size() != 0) e = q.pop_back();
            mpc = {redirect_pc[31:2], 2'b00};
         end
         if (imem_req && imem_gnt) begin
            check("one_outstanding", 32'(q.size()), 32'd0);
            check("fetch_addr", imem_addr, mpc);
            q.push_back({mpc, mpc ^ KEY});
            mpc = mpc + 32'd4;
         end
         pv = inst_valid && stall && !redirect;
      end
   end
   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
   initial begin
      rst = 0; stall = 0; redirect = 0; redirect_pc = '0; imem_gnt = 1; imem_rvalid = 0; imem_rdata = '0;
      repeat (2) @(negedge clk);
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_inst", inst, NOP);
      check("rst_pc", pc, 32'd0);
      check("rst_valid", {31'b0, inst_valid}, 32'd0);
      check("rst_addr", imem_addr, RPC);
      tick;
      rst = 1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         vbits[i] = inst_valid;
      end
      check("throughput", {26'b0, vbits}, 32'h14);
      tick;
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_pc", pc, 32'h8);
         check("stall_inst", inst, 32'h8 ^ KEY);
         check("stall_valid", {31'b0, inst_valid}, 32'd1);
         check("stall_req", {31'b0, imem_req}, 32'd0);
         tick;
      end
      stall = 0;
      @(negedge clk);
      check("unstall_req", {31'b0, imem_req}, 32'd1);
      check("unstall_addr", imem_addr, 32'hC);
      tick;
      mem_lat = 3;
      wait_valid("pc_c", 32'hC);
      tick;
      redirect = 1; redirect_pc = 32'h100;
      @(negedge clk);
      check("rd_wait_req", {31'b0, imem_req}, 32'd0);
      tick;
      redirect = 0;
      mem_lat = 1;
      @(negedge clk);
      check("rd_wait_addr", imem_addr, 32'h100);
      wait_valid("pc_100", 32'h100);
      tick;
      stall = 1;
      wait_valid("pc_104", 32'h104);
      tick;
      redirect = 1; redirect_pc = 32'h203;
      @(negedge clk);
      check("rd_full_req", {31'b0, imem_req}, 32'd0);
      check("rd_full_held", {31'b0, inst_valid}, 32'd1);
      tick;
      redirect = 0; stall = 0;
      @(negedge clk);
      check("rd_full_valid", {31'b0, inst_valid}, 32'd0);
      check("rd_full_addr", imem_addr, 32'h200);
      check("rd_full_newreq", {31'b0, imem_req}, 32'd1);
      tick;
      redirect = 1; redirect_pc = 32'h300;
      @(negedge clk);
      check("rd_rsp_rvalid", {31'b0, imem_rvalid}, 32'd1);
      tick;
      redirect = 0;
      @(negedge clk);
      check("rd_rsp_valid", {31'b0, inst_valid}, 32'd0);
      check("rd_rsp_addr", imem_addr, 32'h300);
      check("rd_rsp_req", {31'b0, imem_req}, 32'd1);
      wait_valid("pc_300", 32'h300);
      tick;
      redirect = 1; redirect_pc = 32'hFFFF_FFFC;
      tick;
      redirect = 0;
      mem_lat = 3;
      wait_valid("pc_top", 32'hFFFF_FFFC);
      check("wrap_addr", imem_addr, 32'h0);
      tick;
      rst = 0; imem_gnt = 0;
      #1;
      check("arst_inst", inst, NOP);
      check("arst_pc", pc, 32'd0);
      check("arst_valid", {31'b0, inst_valid}, 32'd0);
      check("arst_req", {31'b0, imem_req}, 32'd0);
      check("arst_addr", imem_addr, RPC);
      tick;
      rst = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("late_rsp_ignored", {31'b0, inst_valid}, 32'd0);
      end
      tick;
      mem_lat = 1; imem_gnt = 1;
      wait_valid("restart0", RPC);
      wait_valid("restart4", RPC + 32'd4);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues one-outstanding requests to instruction memory.
- Buffers the returned word and presents inst/pc to IF/ID, holding them while stall is high.
- Handles control-flow redirects (branch/jump/flush), including killing an in-flight fetch; presents NOP when no valid instruction is available.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0) driven when no valid instruction

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
stall  in  1  hazard unit: IF/ID holds; current output must be held
redirect  in  1  take redirect_pc this cycle; flushes fetch stage
redirect_pc  in  32  new fetch address; bits[1:0] forced to 0
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address (= pc_q)
imem_gnt  in  1  memory accepts request this cycle (req & gnt = handshake)
imem_rvalid  in  1  read data valid, at least 1 cycle after grant
imem_rdata  in  32  instruction word
inst  out  32  instruction to IF/ID
pc  out  32  address of inst
inst_valid  out  1  inst/pc hold a real fetched instruction

Behaviour:
- Registers:
  - pc_q: next fetch address; reset RESET_PC.
  - req_pc: address of the outstanding request.
  - inst_buf, buf_pc: buffered instruction and its address.
  - kill: discard the next response; reset 0.
  - state: IDLE / WAIT / FULL; reset IDLE.
- Outputs (combinational from state):
  - inst = FULL ? inst_buf : NOP_INST
  - pc = FULL ? buf_pc : 0
  - inst_valid = (state==FULL)
  - imem_addr = pc_q
- imem_req = rst & !redirect & (state==IDLE | (state==FULL & !stall)).
- Reset values (while rst low): imem_req=0, inst=NOP_INST, pc=0, inst_valid=0, imem_addr=RESET_PC.
- Handshake: a request is accepted when imem_req & imem_gnt. On acceptance: req_pc<=pc_q, pc_q<=pc_q+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0), state<=WAIT.
- At most one request outstanding; imem_req is never high in WAIT.
- Transitions (no redirect):
  - IDLE: grant -> WAIT; else stay.
  - WAIT: rvalid & !kill -> FULL, inst_buf<=imem_rdata, buf_pc<=req_pc. rvalid & kill -> IDLE, kill<=0, data dropped. No rvalid -> stay.
  - FULL & stall -> stay; outputs unchanged, no request.
  - FULL & !stall: IF/ID consumes at this edge. Grant -> WAIT, else IDLE.
- Redirect (priority over stall and all other events):
  - Always: pc_q<=redirect_pc&~3; imem_req suppressed this cycle.
  - IDLE or FULL -> IDLE; buffer discarded, inst_valid low next cycle.
  - WAIT without rvalid -> stay WAIT, kill<=1; the stale response is dropped later.
  - WAIT with rvalid same cycle -> IDLE, data dropped, kill<=0.
  - Redirect while kill already set behaves the same; kill stays set until the response arrives.
- imem_rvalid outside WAIT is ignored.
- imem_gnt without imem_req is ignored.
- Throughput with zero-wait memory (gnt same cycle as req, rvalid next cycle): one instruction every 2 cycles (WAIT/FULL alternation).
- Reset mid-operation: all state returns to reset values immediately. A response arriving after reset release lands in IDLE and is ignored. The memory must not depend on the lost request.

Test Plan:
- Reset release, gnt tied 1, rvalid 1 cycle after grant, rdata=addr^32'hA5A5_0000 -> fetches 0x0,0x4,0x8; inst_valid every other cycle with pc=0x0,0x4,0x8 and matching inst; inst=0x00000013 when invalid.
- In FULL with pc=0x8, hold stall high 3 cycles -> inst/pc/inst_valid constant, imem_req=0; stall low -> request addr 0xC same cycle.
- Redirect to 0x100 while WAIT (addr 0x10 outstanding), rvalid 2 cycles later -> 0x10 data never appears (inst_valid stays 0); next fetch addr 0x100; pc output 0x100.
- Redirect to 0x203 in FULL with stall=1 -> next cycle inst_valid=0, imem_addr=0x200; redirect cycle imem_req=0.
- Redirect same cycle as rvalid in WAIT -> state IDLE, data dropped, next request to redirect target.
- Redirect to 0xFFFF_FFFC -> fetch 0xFFFF_FFFC then 0x0000_0000; assert rst mid-WAIT -> outputs NOP/0/0 immediately, fetch restarts at RESET_PC, late rvalid ignored.
